// File: rtl/pwr_event_reader_if.sv
// Read-back handshake bundle for pwr_event_reader.
//   RD_REQ  : read request, four-phase (master -> slave)
//   RD_SEL  : channel select, SW bits (master -> slave)
//   RD_CLR  : clear-on-read (master -> slave)
//   RD_ACK  : one-cycle acknowledge pulse (slave -> master)
//   RD_DATA : captured counter value, CW bits (slave -> master)
interface pwr_event_reader_if #(
  parameter int unsigned CW = 16,
  parameter int unsigned SW = 2
);
  logic          RD_REQ;
  logic [SW-1:0] RD_SEL;
  logic          RD_CLR;
  logic          RD_ACK;
  logic [CW-1:0] RD_DATA;

  modport master (output RD_REQ, output RD_SEL, output RD_CLR,
                  input  RD_ACK, input  RD_DATA);
  modport slave  (input  RD_REQ, input  RD_SEL, input  RD_CLR,
                  output RD_ACK, output RD_DATA);
endinterface

// File: rtl/pwr_event_reader.sv
// Power-event reader: edge-detects NCH event lines, keeps per-channel
// saturating counters with sticky overflow flags, and returns counter
// values over a four-phase request/acknowledge handshake.
//   CLK     : clock, rising edge
//   RESET_N : asynchronous active-low reset
//   EVT     : event lines, a 0->1 transition is one event
//   CLR     : synchronous clear of all counters and overflow flags
//   rd      : read handshake (RD_REQ/RD_SEL/RD_CLR in, RD_ACK/RD_DATA out)
//   OVF     : per-channel sticky saturation flag
//   BUSY    : read FSM not idle
module pwr_event_reader #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16,
  parameter int unsigned SW  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NCH-1:0]        EVT,
  input  logic                  CLR,
  pwr_event_reader_if.slave     rd,
  output logic [NCH-1:0]        OVF,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  evt_q, evt_d;
  logic [NCH-1:0]  ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [CW-1:0]   rd_data_q, rd_data_d;
  logic            ack_q, ack_d;
  logic [NCH-1:0]  rise;
  logic            capt;

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    capt      = 1'b0;
    evt_d     = EVT;
    rise      = EVT & ~evt_q;
    // ACK is registered from the ACK state so the pulse lands one edge
    // after the state, giving the two-edge request-to-ack latency.
    ack_d     = (state_q == ST_ACK);

    unique case (state_q)
      ST_IDLE: if (rd.RD_REQ) state_d = ST_CAPT;
      ST_CAPT: begin
        capt      = 1'b1;
        // Out-of-range selects match no channel and capture zero.
        rd_data_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (32'(rd.RD_SEL) == i) rd_data_d = cnt_q[i];
        end
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: if (!rd.RD_REQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (CLR) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (capt && rd.RD_CLR && (32'(rd.RD_SEL) == i)) begin
        // Clear-on-read keeps an event arriving on the capture edge.
        cnt_d[i] = CW'(rise[i]);
        ovf_d[i] = 1'b0;
      end else if (rise[i]) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CW'(1);
        else                ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      evt_q     <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      evt_q     <= evt_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd.RD_ACK  = ack_q;
  assign rd.RD_DATA = rd_data_q;
  assign OVF        = ovf_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwr_event_reader.sv
// Directed bench for pwr_event_reader. Three instances share one stimulus:
// u_a (NCH=4, CW=16), u_s (NCH=4, CW=4, saturation) and u_t (NCH=3, CW=16,
// out-of-range select). Expected values are hand-computed per step.
module tb_pwr_event_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  evt = '0;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_sel = '0;
  logic        rd_clr = 1'b0;
  logic [3:0]  ovf_a, ovf_s;
  logic [2:0]  ovf_t;
  logic        busy_a, busy_s, busy_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pwr_event_reader_if #(.CW(16), .SW(2)) if_a ();
  pwr_event_reader_if #(.CW(4),  .SW(2)) if_s ();
  pwr_event_reader_if #(.CW(16), .SW(2)) if_t ();

  assign if_a.RD_REQ = rd_req; assign if_a.RD_SEL = rd_sel; assign if_a.RD_CLR = rd_clr;
  assign if_s.RD_REQ = rd_req; assign if_s.RD_SEL = rd_sel; assign if_s.RD_CLR = rd_clr;
  assign if_t.RD_REQ = rd_req; assign if_t.RD_SEL = rd_sel; assign if_t.RD_CLR = rd_clr;

  pwr_event_reader #(.NCH(4), .CW(16), .SW(2)) u_a (
    .CLK(clk), .RESET_N(rst_n), .EVT(evt), .CLR(clr),
    .rd(if_a), .OVF(ovf_a), .BUSY(busy_a));
  pwr_event_reader #(.NCH(4), .CW(4), .SW(2)) u_s (
    .CLK(clk), .RESET_N(rst_n), .EVT(evt), .CLR(clr),
    .rd(if_s), .OVF(ovf_s), .BUSY(busy_s));
  pwr_event_reader #(.NCH(3), .CW(16), .SW(2)) u_t (
    .CLK(clk), .RESET_N(rst_n), .EVT(evt[2:0]), .CLR(clr),
    .rd(if_t), .OVF(ovf_t), .BUSY(busy_t));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled #1 after.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      evt[ch] = 1'b1; step(1);
      evt[ch] = 1'b0; step(1);
    end
  endtask

  // Full read transaction; cap_evt/cap_clr are applied on the capture edge.
  task automatic do_read(input logic [1:0] sel, input logic rclr,
                         input logic [3:0] cap_evt, input logic cap_clr,
                         output logic [15:0] da, output logic [3:0] ds,
                         output logic [15:0] dt);
    rd_req = 1'b1; rd_sel = sel; rd_clr = rclr;
    step(1);                       // request sampled -> CAPT
    evt = evt | cap_evt; clr = cap_clr;
    step(1);                       // capture edge
    evt = evt & ~cap_evt; clr = 1'b0;
    check("ack_before", {31'd0, if_a.RD_ACK}, 32'd0);
    step(1);
    check("ack_pulse", {31'd0, if_a.RD_ACK}, 32'd1);
    da = if_a.RD_DATA; ds = if_s.RD_DATA; dt = if_t.RD_DATA;
    rd_req = 1'b0; rd_clr = 1'b0;
    step(1);                       // WAIT samples RD_REQ low -> IDLE
    check("ack_after", {31'd0, if_a.RD_ACK}, 32'd0);
    check("busy_after", {31'd0, busy_a}, 32'd0);
    step(1);
  endtask

  initial begin
    logic [15:0] da, dt;
    logic [3:0]  ds;
    int          acks;

    // Reset state
    step(3);
    check("rst_ack",  {31'd0, if_a.RD_ACK}, 32'd0);
    check("rst_data", {16'd0, if_a.RD_DATA}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ovf",  {28'd0, ovf_a}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Event count: 5 pulses on ch2, one 10-cycle pulse on ch0
    pulse(2, 5);
    evt[0] = 1'b1; step(10); evt[0] = 1'b0; step(1);
    do_read(2'd2, 1'b0, 4'h0, 1'b0, da, ds, dt);
    check("cnt_ch2", {16'd0, da}, 32'd5);
    check("cnt_ch2_t", {16'd0, dt}, 32'd5);
    do_read(2'd0, 1'b0, 4'h0, 1'b0, da, ds, dt);
    check("cnt_ch0", {16'd0, da}, 32'd1);

    // Saturation on the CW=4 instance
    pulse(1, 17);
    check("ovf_s", {28'd0, ovf_s}, 32'h2);
    check("ovf_a", {28'd0, ovf_a}, 32'h0);
    do_read(2'd1, 1'b1, 4'h0, 1'b0, da, ds, dt);
    check("sat_rd", {28'd0, ds}, 32'd15);
    check("wide_rd", {16'd0, da}, 32'd17);
    check("ovf_s_clr", {28'd0, ovf_s}, 32'h0);
    do_read(2'd1, 1'b0, 4'h0, 1'b0, da, ds, dt);
    check("sat_after_clr", {28'd0, ds}, 32'd0);
    check("wide_after_clr", {16'd0, da}, 32'd0);

    // Rise on ch3 coincides with clear-on-read capture of ch3
    pulse(3, 7);
    do_read(2'd3, 1'b1, 4'h8, 1'b0, da, ds, dt);
    check("simul_rd", {16'd0, da}, 32'd7);
    do_read(2'd3, 1'b0, 4'h0, 1'b0, da, ds, dt);
    check("simul_next", {16'd0, da}, 32'd1);

    // CLR on the same edge as a rise on every channel
    evt = 4'hF; clr = 1'b1; step(1);
    evt = 4'h0; clr = 1'b0; step(1);
    for (int c = 0; c < 4; c++) begin
      do_read(2'(c), 1'b0, 4'h0, 1'b0, da, ds, dt);
      check("clr_all", {16'd0, da}, 32'd0);
    end
    pulse(0, 3);
    do_read(2'd0, 1'b0, 4'h0, 1'b1, da, ds, dt);
    check("clr_capt_pre", {16'd0, da}, 32'd3);
    do_read(2'd0, 1'b0, 4'h0, 1'b0, da, ds, dt);
    check("clr_capt_post", {16'd0, da}, 32'd0);

    // RD_REQ held high for 20 cycles
    acks = 0;
    rd_req = 1'b1; rd_sel = 2'd2;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (if_a.RD_ACK) acks++;
    end
    check("busy_held", {31'd0, busy_a}, 32'd1);
    rd_req = 1'b0;
    step(1);
    check("acks_held", acks, 32'd1);
    check("busy_held_end", {31'd0, busy_a}, 32'd0);

    // RD_REQ dropped while in CAPT
    acks = 0;
    rd_req = 1'b1; step(1);
    rd_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (if_a.RD_ACK) acks++;
    end
    check("acks_early_drop", acks, 32'd1);
    check("busy_early_drop", {31'd0, busy_a}, 32'd0);

    // Out-of-range select on NCH=3 instance
    pulse(1, 2);
    pulse(3, 2);
    do_read(2'd1, 1'b0, 4'h0, 1'b0, da, ds, dt);
    check("t_ch1", {16'd0, dt}, 32'd2);
    do_read(2'd3, 1'b1, 4'h0, 1'b0, da, ds, dt);
    check("t_sel_oor", {16'd0, dt}, 32'd0);
    check("a_sel3", {16'd0, da}, 32'd2);

    // Asynchronous reset in the middle of ACK
    pulse(1, 16);
    check("ovf_s_pre_rst", {28'd0, ovf_s}, 32'h2);
    pulse(2, 4);
    rd_req = 1'b1; rd_sel = 2'd2;
    step(3);
    check("mid_ack", {31'd0, if_a.RD_ACK}, 32'd1);
    check("mid_data", {16'd0, if_a.RD_DATA}, 32'd4);
    check("mid_busy", {31'd0, busy_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ack",  {31'd0, if_a.RD_ACK}, 32'd0);
    check("async_busy", {31'd0, busy_a}, 32'd0);
    check("async_data", {16'd0, if_a.RD_DATA}, 32'd0);
    check("async_ovf",  {28'd0, ovf_s}, 32'h0);
    rd_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    for (int c = 0; c < 4; c++) begin
      do_read(2'(c), 1'b0, 4'h0, 1'b0, da, ds, dt);
      check("post_rst_cnt", {16'd0, da}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
